// File: rtl/bcd_display_ctrl_if.sv
// ----------------------------------------------------------------------------
// bcd_display_ctrl_if
// Signal bundle between a requester and the BCD display controller.
//   Start      : conversion request (requester -> controller)
//   In_Num     : 13-bit unsigned value to convert (requester -> controller)
//   Busy       : conversion in progress
//   Done       : one-cycle completion strobe
//   Thousands/Hundreds/Tens/Ones : registered BCD result digits
//   Anode      : active-low one-hot digit enable, bit 0 = ones digit
//   Segments   : active-low {g,f,e,d,c,b,a}
// The controller connects through the slave modport, the requester through
// the master modport.
// ----------------------------------------------------------------------------
interface bcd_display_ctrl_if;
   logic        Start;
   logic [12:0] In_Num;
   logic        Busy;
   logic        Done;
   logic [3:0]  Thousands;
   logic [3:0]  Hundreds;
   logic [3:0]  Tens;
   logic [3:0]  Ones;
   logic [3:0]  Anode;
   logic [6:0]  Segments;

   modport master (
      output Start, In_Num,
      input  Busy, Done, Thousands, Hundreds, Tens, Ones, Anode, Segments
   );

   modport slave (
      input  Start, In_Num,
      output Busy, Done, Thousands, Hundreds, Tens, Ones, Anode, Segments
   );
endinterface

// File: rtl/bcd_display_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_display_ctrl
// Converts a 13-bit binary value to four BCD digits with a shift-and-add-3
// (double dabble) sequencer, holds the result in output digit registers and
// time-multiplexes it onto a 4-digit common-anode 7-segment display.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of bcd_display_ctrl_if (Start/In_Num request, Busy,
//          Done, result digits, Anode, Segments)
// Parameters:
//   REFRESH_DIV : clocks per digit scan slot (2 .. 131071)
//   BLANK_LZ    : 1 blanks leading zeros (ones digit is never blanked)
// ----------------------------------------------------------------------------
module bcd_display_ctrl #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   bcd_display_ctrl_if.slave  bus
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [12:0] bin;
   logic [15:0] scr;
   logic [3:0]  bit_cnt;
   logic        busy;
   logic        done;
   logic [3:0]  thou;
   logic [3:0]  hund;
   logic [3:0]  tens;
   logic [3:0]  ones;

   logic [RW-1:0] ref_cnt;
   logic [1:0]    sel;

   logic [15:0] scr_adj;
   logic [28:0] sr_next;

   logic [3:0]  anode_c;
   logic [3:0]  digit_c;
   logic        blank_c;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // One double-dabble step: correct each BCD digit, then shift the whole
   // {digits, remaining binary} word left so the binary MSB enters the ones.
   assign scr_adj = {add3(scr[15:12]), add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0])};
   assign sr_next = {scr_adj, bin} << 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin     <= '0;
         scr     <= '0;
         bit_cnt <= '0;
         thou    <= '0;
         hund    <= '0;
         tens    <= '0;
         ones    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  bin     <= bus.In_Num;
                  scr     <= '0;
                  bit_cnt <= 4'd13;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scr     <= sr_next[28:13];
               bin     <= sr_next[12:0];
               bit_cnt <= bit_cnt - 4'd1;
               // Last shift: publish directly from the shifted word so the
               // result lands on the same edge as the final step.
               if (bit_cnt == 4'd1) begin
                  thou  <= sr_next[28:25];
                  hund  <= sr_next[24:21];
                  tens  <= sr_next[20:17];
                  ones  <= sr_next[16:13];
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_cnt <= '0;
         sel     <= 2'd0;
      end else if (ref_cnt == REF_MAX) begin
         ref_cnt <= '0;
         sel     <= sel + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + RW'(1);
      end
   end

   // Digit mux and leading-zero blanking; a digit is blanked only when it
   // and every more significant digit are zero.
   always_comb begin
      anode_c = 4'b1110;
      digit_c = ones;
      blank_c = 1'b0;
      case (sel)
         2'd1: begin
            anode_c = 4'b1101;
            digit_c = tens;
            blank_c = BLANK_LZ && (thou == 4'd0) && (hund == 4'd0) && (tens == 4'd0);
         end
         2'd2: begin
            anode_c = 4'b1011;
            digit_c = hund;
            blank_c = BLANK_LZ && (thou == 4'd0) && (hund == 4'd0);
         end
         2'd3: begin
            anode_c = 4'b0111;
            digit_c = thou;
            blank_c = BLANK_LZ && (thou == 4'd0);
         end
         default: begin
            anode_c = 4'b1110;
            digit_c = ones;
            blank_c = 1'b0;
         end
      endcase
   end

   assign bus.Busy      = busy;
   assign bus.Done      = done;
   assign bus.Thousands = thou;
   assign bus.Hundreds  = hund;
   assign bus.Tens      = tens;
   assign bus.Ones      = ones;
   assign bus.Anode     = anode_c;
   assign bus.Segments  = blank_c ? 7'b1111111 : seg7(digit_c);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_ctrl
// Self-checking bench for bcd_display_ctrl with REFRESH_DIV=4, BLANK_LZ=1.
// The reference model works on decimal values: expected digits come from
// division by powers of ten, the scan slot from the number of clocks since
// reset release, and blanking from "value below 10^position".
// ----------------------------------------------------------------------------
module tb_bcd_display_ctrl;

   localparam int DIV = 4;
   localparam int PW[4] = '{1, 10, 100, 1000};
   localparam logic [6:0] SEG_TAB[10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic clk = 1'b0;
   logic rst = 1'b1;

   bcd_display_ctrl_if bus ();

   bcd_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_val = 0;   // value the display is expected to show
   int cyc = 0;       // clocks since reset release

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic logic [15:0] exp_digits(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int exp_sel();
      return (cyc / DIV) % 4;
   endfunction

   function automatic logic [3:0] exp_anode(input int s);
      logic [3:0] a;
      a = 4'b1111;
      a[s] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int s);
      if (s > 0 && v < PW[s]) return 7'b1111111;
      return SEG_TAB[(v / PW[s]) % 10];
   endfunction

   function automatic logic [15:0] got_digits();
      return {bus.Thousands, bus.Hundreds, bus.Tens, bus.Ones};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Conversion from IDLE: E0 is the first edge after Start is raised.
   task automatic test_conversion(input int v);
      int old;
      int shown;
      old = exp_val;
      bus.In_Num = 13'(v);
      bus.Start  = 1'b1;
      cycle();
      bus.Start = 1'b0;
      n_chk++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0)
         $display("FAIL conv%0d_accept: busy=%b done=%b expected busy=1 done=0", v, bus.Busy, bus.Done);
         else ;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) n_fail++;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         shown = (k >= 13) ? v : old;
         n_chk++;
         if (bus.Busy !== (k < 14) || bus.Done !== (k == 13)) begin
            n_fail++;
            $display("FAIL conv%0d_ctrl_E%0d: busy=%b done=%b expected busy=%b done=%b",
                     v, k, bus.Busy, bus.Done, (k < 14), (k == 13));
         end
         n_chk++;
         if (got_digits() !== exp_digits(shown)) begin
            n_fail++;
            $display("FAIL conv%0d_digits_E%0d: got %h expected %h", v, k, got_digits(), exp_digits(shown));
         end
         n_chk++;
         if (bus.Anode !== exp_anode(exp_sel()) || bus.Segments !== exp_seg(shown, exp_sel())) begin
            n_fail++;
            $display("FAIL conv%0d_disp_E%0d: anode=%b seg=%b expected anode=%b seg=%b", v, k,
                     bus.Anode, bus.Segments, exp_anode(exp_sel()), exp_seg(shown, exp_sel()));
         end
      end
      exp_val = v;
   endtask

   task automatic test_reset();
      bus.Start  = 1'b0;
      bus.In_Num = '0;
      #3 rst = 1'b0;
      repeat (3) cycle();
      n_chk++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || got_digits() !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b digits=%h expected 0 0 0000", bus.Busy, bus.Done, got_digits());
      end
      n_chk++;
      if (bus.Anode !== 4'b1110 || bus.Segments !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_display: anode=%b seg=%b expected 1110 1000000", bus.Anode, bus.Segments);
      end
      rst = 1'b1;
      exp_val = 0;
      cycle();
   endtask

   task automatic test_full_and_zero();
      test_conversion(8191);
      test_conversion(0);
      for (int i = 0; i < 16; i++) begin
         cycle();
         n_chk++;
         if ((bus.Anode == 4'b1110 && bus.Segments !== 7'b1000000) ||
             (bus.Anode != 4'b1110 && bus.Segments !== 7'b1111111) ||
             bus.Anode !== exp_anode(exp_sel())) begin
            n_fail++;
            $display("FAIL zero_blank_%0d: anode=%b seg=%b expected anode=%b seg=%b", i,
                     bus.Anode, bus.Segments, exp_anode(exp_sel()), exp_seg(0, exp_sel()));
         end
      end
   endtask

   task automatic test_ignore_start();
      int dones;
      dones = 0;
      bus.In_Num = 13'd500;
      bus.Start  = 1'b1;
      cycle();
      bus.Start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 5) begin
            bus.In_Num = 13'd77;
            bus.Start  = 1'b1;
         end
         cycle();
         if (k == 5) bus.Start = 1'b0;
         if (bus.Done === 1'b1) dones++;
         n_chk++;
         if (bus.Busy !== (k < 14)) begin
            n_fail++;
            $display("FAIL ignore_busy_E%0d: busy=%b expected %b", k, bus.Busy, (k < 14));
         end
      end
      n_chk++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL ignore_done_count: got %0d expected 1", dones);
      end
      n_chk++;
      if (got_digits() !== exp_digits(500)) begin
         n_fail++;
         $display("FAIL ignore_digits: got %h expected %h", got_digits(), exp_digits(500));
      end
      exp_val = 500;
   endtask

   task automatic test_reset_abort();
      bus.In_Num = 13'd8191;
      bus.Start  = 1'b1;
      cycle();
      bus.Start = 1'b0;
      repeat (6) cycle();
      rst = 1'b0;
      #1;
      n_chk++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || got_digits() !== 16'h0000) begin
         n_fail++;
         $display("FAIL abort_state: busy=%b done=%b digits=%h expected 0 0 0000", bus.Busy, bus.Done, got_digits());
      end
      exp_val = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_chk++;
         if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Anode !== 4'b1110 || bus.Segments !== 7'b1000000) begin
            n_fail++;
            $display("FAIL abort_hold_%0d: done=%b busy=%b anode=%b seg=%b expected 0 0 1110 1000000",
                     i, bus.Done, bus.Busy, bus.Anode, bus.Segments);
         end
      end
      // Release together with Start: the first edge with rst=1 accepts.
      rst = 1'b1;
      test_conversion(4321);
   endtask

   task automatic test_back_to_back();
      int vals[3];
      int idx;
      int last_t;
      for (int i = 0; i < 3; i++) vals[i] = int'($urandom_range(0, 8191));
      idx = 0;
      last_t = 0;
      bus.In_Num = 13'(vals[0]);
      bus.Start  = 1'b1;
      for (int t = 1; t <= 80 && idx < 3; t++) begin
         cycle();
         if (bus.Done === 1'b1) begin
            n_chk++;
            if (got_digits() !== exp_digits(vals[idx])) begin
               n_fail++;
               $display("FAIL b2b_digits_%0d: got %h expected %h", idx, got_digits(), exp_digits(vals[idx]));
            end
            if (idx > 0) begin
               n_chk++;
               if (t - last_t != 15) begin
                  n_fail++;
                  $display("FAIL b2b_period_%0d: got %0d expected 15", idx, t - last_t);
               end
            end
            last_t = t;
            idx++;
            if (idx < 3) bus.In_Num = 13'(vals[idx]);
            else bus.Start = 1'b0;
         end
      end
      bus.Start = 1'b0;
      n_chk++;
      if (idx != 3) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d conversions expected 3", idx);
      end
      exp_val = vals[2];
      repeat (3) cycle();
      n_chk++;
      if (bus.Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: busy=%b expected 0", bus.Busy);
      end
   endtask

   task automatic test_random();
      int edge_vals[6];
      edge_vals = '{9, 10, 99, 100, 999, 1000};
      foreach (edge_vals[i]) test_conversion(edge_vals[i]);
      for (int i = 0; i < 5; i++) test_conversion(int'($urandom_range(0, 8191)));
   endtask

   task automatic test_scan_0042();
      logic [3:0] an_tab[4];
      logic [6:0] sg_tab[4];
      int guard;
      an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      sg_tab = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};
      test_conversion(42);
      guard = 0;
      while (cyc % 16 != 0 && guard < 20) begin
         cycle();
         guard++;
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (bus.Anode !== an_tab[i / 4] || bus.Segments !== sg_tab[i / 4]) begin
            n_fail++;
            $display("FAIL scan42_%0d: anode=%b seg=%b expected anode=%b seg=%b", i,
                     bus.Anode, bus.Segments, an_tab[i / 4], sg_tab[i / 4]);
         end
         cycle();
      end
   endtask

   initial begin
      bus.Start  = 1'b0;
      bus.In_Num = '0;
      test_reset();
      test_conversion(1234);
      test_full_and_zero();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_scan_0042();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
